branch_resolve_unit: RTL and testbench
======================================

Name: branch_resolve_unit

Overview:
- Resolution-side counterpart of the saturating-counter branch predictor.
- Queues in-flight predictions in order and compares each one with the actual branch outcome when it resolves.
- Drives the training strobe and taken bit back into the predictor, and raises a misprediction flush.
- Keeps saturating accuracy statistics.

Parameters:
DEPTH, 4, max outstanding unresolved predictions; power of two, >=2
CNT_W, 16, width of statistics counters

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
pred_valid  in  1  new prediction issued this cycle
pred_taken  in  1  predicted direction (predictor's prediction output)
pred_ready  out  1  queue can accept a prediction
res_valid  in  1  oldest outstanding branch resolved this cycle
res_taken  in  1  actual outcome of that branch
train_valid  out  1  one-cycle strobe: apply training update to predictor
train_taken  out  1  outcome to train with (feeds predictor taken input)
mispredict  out  1  one-cycle pulse: resolved branch was mispredicted, younger work flushed
orphan  out  1  one-cycle pulse: res_valid arrived with empty queue
outstanding  out  $clog2(DEPTH)+1  current queue occupancy
total_cnt  out  CNT_W  resolved branches, saturating
miss_cnt  out  CNT_W  mispredictions, saturating

Behaviour:
- Reset (rst_n=0 at posedge): queue empty, state RUN, all outputs 0 except pred_ready=1. Reset overrides every other input, including mid-flush.
- Queue: circular FIFO, DEPTH entries of 1 bit. Read/write pointers are $clog2(DEPTH) bits and wrap naturally. Occupancy is $clog2(DEPTH)+1 bits.
- pred_ready = (state==RUN) && (outstanding < DEPTH). It is combinational from registered state and does not depend on same-cycle res_valid. A push when full is not accepted, even if a pop occurs in the same cycle.
- Push: pred_valid && pred_ready writes pred_taken at the tail.
- Pop: res_valid && outstanding>0 removes the head entry. Let hit = (head == res_taken).
- Registered outputs, valid on the cycle after the pop (latency 1):
  - train_valid=1, train_taken=res_taken.
  - mispredict=!hit.
  - total_cnt+1.
  - miss_cnt+1 when !hit.
  - Counters saturate at all-ones and never wrap.
- Correct prediction with simultaneous push: both occur and occupancy is unchanged.
- Mispredict:
  - At the pop edge, the whole queue is cleared (both pointers zero, occupancy 0).
  - A same-cycle push is discarded, because it is younger and speculative.
  - State goes to FLUSH.
- State machine (2 states):
  - RUN: normal operation. Goes to FLUSH on a mispredicting pop.
  - FLUSH: lasts exactly one cycle. mispredict=1 and pred_ready=0 during this cycle. pred_valid and res_valid are ignored (res_valid in FLUSH also does not assert orphan). Unconditionally returns to RUN.
- Orphan: res_valid && outstanding==0 in RUN.
  - orphan=1 the next cycle.
  - No training, no counter change.
  - A same-cycle push still occurs normally.
- train_valid, mispredict and orphan are single-cycle pulses. They deassert the following cycle unless retriggered.
- Back-to-back correct resolutions produce back-to-back train_valid pulses.

Test Plan:
- Reset, then push T,N,T; resolve T,N,T on consecutive cycles -> train_valid high 3 cycles with train_taken 1,0,1; mispredict never; total_cnt=3, miss_cnt=0, outstanding=0.
- Push 4 predictions (DEPTH=4) -> pred_ready=0 with outstanding=4; a 5th pred_valid is dropped; resolve one plus pred_valid in the same cycle -> push still rejected that cycle, accepted the next.
- Push T,T,T; resolve first with res_taken=0 plus a same-cycle push -> next cycle mispredict=1, train_taken=0, outstanding=0, pred_ready=0, miss_cnt=1; the following cycle returns to RUN with pred_ready=1.
- res_valid on empty queue with pred_valid=1, pred_taken=1 -> orphan=1 next cycle, train_valid=0, counters unchanged, outstanding=1.
- Set CNT_W=2; resolve 5 mispredictions, re-pushing between them -> miss_cnt and total_cnt stick at 3.
- Push 3 predictions, assert rst_n=0 for one cycle during FLUSH -> outstanding=0, mispredict=0, pred_ready=1, counters 0.

Source files
------------

// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: tracks in-flight predictions in order, compares each with its
// actual outcome, trains the predictor, flushes on misprediction and keeps accuracy counters.
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pred_valid,
    input  logic                       pred_taken,
    output logic                       pred_ready,
    input  logic                       res_valid,
    input  logic                       res_taken,
    output logic                       train_valid,
    output logic                       train_taken,
    output logic                       mispredict,
    output logic                       orphan,
    output logic [$clog2(DEPTH):0]     outstanding,
    output logic [CNT_W-1:0]           total_cnt,
    output logic [CNT_W-1:0]           miss_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t           state, state_next;
    logic [DEPTH-1:0] queue;
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [OCC_W-1:0] occ;
    logic             in_run, push, pop, hit, miss, orph;

    assign outstanding = occ;

    // NOTE: every signal driven here gets a value before any condition, so no latch is inferred.
    always_comb begin
        in_run     = (state == RUN);
        pred_ready = in_run && (occ < OCC_W'(DEPTH));
        push       = pred_valid && pred_ready;
        pop        = in_run && res_valid && (occ != '0);
        orph       = in_run && res_valid && (occ == '0);
        hit        = (queue[rd_ptr] == res_taken);
        miss       = pop && !hit;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (miss) state_next = FLUSH;
            FLUSH:   state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= RUN;
        else        state <= state_next;
    end

    // NOTE: queue storage is deliberately not reset; occupancy and pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (push && !miss) queue[wr_ptr] <= pred_taken;
    end

    // A mispredict discards every queued entry plus any same-cycle (younger) push.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else if (miss) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            train_valid <= 1'b0;
            train_taken <= 1'b0;
            mispredict  <= 1'b0;
            orphan      <= 1'b0;
            total_cnt   <= '0;
            miss_cnt    <= '0;
        end else begin
            train_valid <= pop;
            train_taken <= pop && res_taken;
            mispredict  <= miss;
            orphan      <= orph;
            if (pop && (total_cnt != '1)) total_cnt <= total_cnt + CNT_W'(1);
            if (miss && (miss_cnt != '1)) miss_cnt <= miss_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_branch_resolve_unit;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n, pred_valid, pred_taken, res_valid, res_taken;
    logic pred_ready, train_valid, train_taken, mispredict, orphan;
    logic [$clog2(DEPTH):0] outstanding;
    logic [15:0] total_cnt, miss_cnt;
    logic pred_ready2, train_valid2, train_taken2, mispredict2, orphan2;
    logic [$clog2(DEPTH):0] outstanding2;
    logic [1:0] total_cnt2, miss_cnt2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_ready(pred_ready), .res_valid(res_valid), .res_taken(res_taken),
        .train_valid(train_valid), .train_taken(train_taken), .mispredict(mispredict),
        .orphan(orphan), .outstanding(outstanding), .total_cnt(total_cnt), .miss_cnt(miss_cnt)
    );

    branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_ready(pred_ready2), .res_valid(res_valid), .res_taken(res_taken),
        .train_valid(train_valid2), .train_taken(train_taken2), .mispredict(mispredict2),
        .orphan(orphan2), .outstanding(outstanding2), .total_cnt(total_cnt2), .miss_cnt(miss_cnt2)
    );

    // Reference model: an ordered queue of predictions, a flush flag and unbounded tallies.
    bit mq[$];
    bit m_flush;
    int m_tot, m_miss;
    bit e_tv, e_tt, e_mis, e_orph;

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic void model_step();
        bit rdy;
        bit hit_m;
        e_tv = 0; e_tt = 0; e_mis = 0; e_orph = 0;
        if (!rst_n) begin
            mq.delete();
            m_flush = 0;
            m_tot = 0;
            m_miss = 0;
        end else if (m_flush) begin
            m_flush = 0;
        end else begin
            rdy = (mq.size() < DEPTH);
            if (res_valid && mq.size() == 0) e_orph = 1;
            if (res_valid && mq.size() > 0) begin
                hit_m = (mq[0] == res_taken);
                e_tv = 1;
                e_tt = res_taken;
                m_tot++;
                if (!hit_m) begin
                    m_miss++;
                    e_mis = 1;
                    mq.delete();
                    m_flush = 1;
                end else begin
                    void'(mq.pop_front());
                end
            end
            if (pred_valid && rdy && !e_mis) mq.push_back(pred_taken);
        end
    endfunction

    task automatic drive(input bit pv, input bit pt, input bit rv, input bit rt);
        pred_valid = pv;
        pred_taken = pt;
        res_valid  = rv;
        res_taken  = rt;
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", outstanding); end
        checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL reset_pred_ready: got %b expected 1", pred_ready); end
        checks++; if ({train_valid, mispredict, orphan} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b expected 000", {train_valid, mispredict, orphan}); end
        checks++; if (total_cnt !== 16'd0 || miss_cnt !== 16'd0) begin errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", total_cnt, miss_cnt); end
    endtask

    task automatic test_in_order();
        bit exp_t[3] = '{1'b1, 1'b0, 1'b1};
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, exp_t[i], 0, 0);
        checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL inorder_fill: got %0d expected 3", outstanding); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, exp_t[i]);
            checks++; if (train_valid !== 1'b1) begin errors++; $display("FAIL inorder_tv%0d: got %b expected 1", i, train_valid); end
            checks++; if (train_taken !== exp_t[i]) begin errors++; $display("FAIL inorder_tt%0d: got %b expected %b", i, train_taken, exp_t[i]); end
            checks++; if (mispredict !== 1'b0) begin errors++; $display("FAIL inorder_mis%0d: got %b expected 0", i, mispredict); end
        end
        checks++; if (total_cnt !== 16'd3 || miss_cnt !== 16'd0) begin errors++; $display("FAIL inorder_counters: got %0d/%0d expected 3/0", total_cnt, miss_cnt); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL inorder_drain: got %0d expected 0", outstanding); end
        drive(0, 0, 0, 0);
        checks++; if (train_valid !== 1'b0) begin errors++; $display("FAIL inorder_tv_drop: got %b expected 0", train_valid); end
    endtask

    task automatic test_full();
        do_reset();
        repeat (4) drive(1, 1, 0, 0);
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_occ: got %0d expected 4", outstanding); end
        checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", pred_ready); end
        drive(1, 0, 0, 0);
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_drop: got %0d expected 4", outstanding); end
        drive(1, 0, 1, 1);
        checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL full_pop_push: got %0d expected 3", outstanding); end
        checks++; if (train_valid !== 1'b1 || mispredict !== 1'b0) begin errors++; $display("FAIL full_pop_train: got tv=%b mis=%b expected tv=1 mis=0", train_valid, mispredict); end
        drive(1, 0, 0, 0);
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d expected 4", outstanding); end
    endtask

    task automatic test_mispredict();
        do_reset();
        repeat (3) drive(1, 1, 0, 0);
        drive(1, 1, 1, 0);
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL mis_pulse: got %b expected 1", mispredict); end
        checks++; if (train_valid !== 1'b1 || train_taken !== 1'b0) begin errors++; $display("FAIL mis_train: got tv=%b tt=%b expected tv=1 tt=0", train_valid, train_taken); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL mis_clear: got %0d expected 0", outstanding); end
        checks++; if (pred_ready !== 1'b0) begin errors++; $display("FAIL mis_ready: got %b expected 0", pred_ready); end
        checks++; if (miss_cnt !== 16'd1) begin errors++; $display("FAIL mis_cnt: got %0d expected 1", miss_cnt); end
        drive(1, 1, 1, 1);
        checks++; if (mispredict !== 1'b0 || orphan !== 1'b0 || train_valid !== 1'b0) begin errors++; $display("FAIL flush_ignore_pulses: got mis=%b orph=%b tv=%b expected 000", mispredict, orphan, train_valid); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL flush_ignore_push: got %0d expected 0", outstanding); end
        checks++; if (pred_ready !== 1'b1) begin errors++; $display("FAIL flush_return: got %b expected 1", pred_ready); end
        checks++; if (total_cnt !== 16'd1) begin errors++; $display("FAIL flush_total: got %0d expected 1", total_cnt); end
    endtask

    task automatic test_orphan();
        do_reset();
        drive(1, 1, 1, 0);
        checks++; if (orphan !== 1'b1) begin errors++; $display("FAIL orphan_pulse: got %b expected 1", orphan); end
        checks++; if (train_valid !== 1'b0) begin errors++; $display("FAIL orphan_no_train: got %b expected 0", train_valid); end
        checks++; if (total_cnt !== 16'd0 || miss_cnt !== 16'd0) begin errors++; $display("FAIL orphan_counters: got %0d/%0d expected 0/0", total_cnt, miss_cnt); end
        checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL orphan_push: got %0d expected 1", outstanding); end
        drive(0, 0, 1, 1);
        checks++; if (orphan !== 1'b0 || train_valid !== 1'b1 || train_taken !== 1'b1) begin errors++; $display("FAIL orphan_after: got orph=%b tv=%b tt=%b expected 0 1 1", orphan, train_valid, train_taken); end
    endtask

    task automatic test_saturate();
        do_reset();
        repeat (5) begin
            drive(1, 1, 0, 0);
            drive(0, 0, 1, 0);
            drive(0, 0, 0, 0);
        end
        checks++; if (miss_cnt2 !== 2'd3 || total_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_narrow: got %0d/%0d expected 3/3", total_cnt2, miss_cnt2); end
        checks++; if (miss_cnt !== 16'd5 || total_cnt !== 16'd5) begin errors++; $display("FAIL sat_wide: got %0d/%0d expected 5/5", total_cnt, miss_cnt); end
    endtask

    task automatic test_reset_in_flush();
        do_reset();
        repeat (3) drive(1, 1, 0, 0);
        drive(0, 0, 1, 0);
        checks++; if (mispredict !== 1'b1) begin errors++; $display("FAIL rstflush_enter: got %b expected 1", mispredict); end
        rst_n = 1'b0;
        drive(1, 1, 1, 0);
        rst_n = 1'b1;
        checks++; if (outstanding !== 3'd0 || mispredict !== 1'b0 || pred_ready !== 1'b1) begin errors++; $display("FAIL rstflush_state: got occ=%0d mis=%b rdy=%b expected 0 0 1", outstanding, mispredict, pred_ready); end
        checks++; if (total_cnt !== 16'd0 || miss_cnt !== 16'd0) begin errors++; $display("FAIL rstflush_counters: got %0d/%0d expected 0/0", total_cnt, miss_cnt); end
    endtask

    task automatic test_random();
        bit e_rdy;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            drive($urandom_range(0, 2) != 0, 1'($urandom), 1'($urandom), 1'($urandom));
            e_rdy = !m_flush && (mq.size() < DEPTH);
            checks++; if (train_valid !== e_tv) begin errors++; $display("FAIL rnd_tv@%0d: got %b expected %b", n, train_valid, e_tv); end
            if (e_tv) begin
                checks++; if (train_taken !== e_tt) begin errors++; $display("FAIL rnd_tt@%0d: got %b expected %b", n, train_taken, e_tt); end
            end
            checks++; if (mispredict !== e_mis) begin errors++; $display("FAIL rnd_mis@%0d: got %b expected %b", n, mispredict, e_mis); end
            checks++; if (orphan !== e_orph) begin errors++; $display("FAIL rnd_orph@%0d: got %b expected %b", n, orphan, e_orph); end
            checks++; if (int'(outstanding) != mq.size()) begin errors++; $display("FAIL rnd_occ@%0d: got %0d expected %0d", n, outstanding, mq.size()); end
            checks++; if (pred_ready !== e_rdy) begin errors++; $display("FAIL rnd_ready@%0d: got %b expected %b", n, pred_ready, e_rdy); end
            checks++; if (int'(total_cnt) != sat(m_tot, 65535) || int'(miss_cnt) != sat(m_miss, 65535)) begin errors++; $display("FAIL rnd_cnt@%0d: got %0d/%0d expected %0d/%0d", n, total_cnt, miss_cnt, sat(m_tot, 65535), sat(m_miss, 65535)); end
            checks++; if (int'(total_cnt2) != sat(m_tot, 3) || int'(miss_cnt2) != sat(m_miss, 3)) begin errors++; $display("FAIL rnd_cnt2@%0d: got %0d/%0d expected %0d/%0d", n, total_cnt2, miss_cnt2, sat(m_tot, 3), sat(m_miss, 3)); end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        pred_valid = 1'b0;
        pred_taken = 1'b0;
        res_valid = 1'b0;
        res_taken = 1'b0;
        test_reset();
        test_in_order();
        test_full();
        test_mispredict();
        test_orphan();
        test_saturate();
        test_reset_in_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
